// File: rtl/p_addsub_arb.sv
// Two-requester round-robin front end for one shared packed add/subtract unit,
// with a one-entry response buffer per requester and pack-width screening.

package p_addsub_arb_pkg;

    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [4:0]  pw;
        logic        sub;
    } req_t;

    typedef struct packed {
        logic [31:0] result;
        logic        err;
    } rsp_t;

endpackage

// Packed add/subtract: 32/16/8/4/2-bit lanes selected by one-hot pw, no carry
// crosses a lane boundary. Built from 2-bit segments with a per-segment carry kill.
module p_addsub (
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
    input  logic        sub,
    output logic [31:0] result
);

    localparam int NSEG = 16;

    logic       c;
    logic       cin;
    logic       start;
    logic [2:0] t;

    always_comb begin
        result = '0;
        t      = '0;
        start  = 1'b0;
        cin    = 1'b0;
        // Seeding the chain with sub makes segment 0 correct even for an all-zero pw.
        c      = sub;
        for (int k = 0; k < NSEG; k++) begin
            start = (pw[0] & (k % 16 == 0)) | (pw[1] & (k % 8 == 0)) |
                    (pw[2] & (k % 4 == 0))  | (pw[3] & (k % 2 == 0)) | pw[4];
            cin   = start ? sub : c;
            t     = {1'b0, lhs[2*k +: 2]} + {1'b0, rhs[2*k +: 2] ^ {2{sub}}} + {2'b0, cin};
            result[2*k +: 2] = t[1:0];
            c     = t[2];
        end
    end

endmodule

// One-entry response buffer for a single requester.
module p_addsub_arb_buf
    import p_addsub_arb_pkg::*;
(
    input  logic g_clk,
    input  logic g_resetn,
    input  logic load,
    input  logic drain,
    input  rsp_t rsp_in,
    output logic valid,
    output rsp_t rsp
);

    // A load in the same cycle as a drain wins, so the entry stays occupied.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            valid <= 1'b0;
            rsp   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            rsp   <= rsp_in;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

module p_addsub_arb
    import p_addsub_arb_pkg::*;
#(
    parameter bit PW_CHECK = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_lhs,
    input  logic [31:0] req0_rhs,
    input  logic [4:0]  req0_pw,
    input  logic        req0_sub,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_lhs,
    input  logic [31:0] req1_rhs,
    input  logic [4:0]  req1_pw,
    input  logic        req1_sub,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_err,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_err
);

    localparam int NUM_REQ = 2;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    req_t [NUM_REQ-1:0] req;
    rsp_t [NUM_REQ-1:0] rsp;

    req_t        sel;
    logic [31:0] sum;
    logic        pw_ok;
    rsp_t        rsp_nxt;
    logic        last;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign req[0]    = '{lhs: req0_lhs, rhs: req0_rhs, pw: req0_pw, sub: req0_sub};
    assign req[1]    = '{lhs: req1_lhs, rhs: req1_rhs, pw: req1_pw, sub: req1_sub};

    // A requester may only win if its buffer will have room at the edge.
    assign elig     = req_valid & (~rsp_valid | rsp_ready);
    assign grant[0] = elig[0] & (~elig[1] | last);
    assign grant[1] = elig[1] & (~elig[0] | ~last);

    assign sel = grant[1] ? req[1] : req[0];

    p_addsub u_addsub (
        .lhs    (sel.lhs),
        .rhs    (sel.rhs),
        .pw     (sel.pw),
        .sub    (sel.sub),
        .result (sum)
    );

    assign pw_ok          = (sel.pw != 5'd0) && ((sel.pw & (sel.pw - 5'd1)) == 5'd0);
    assign rsp_nxt.err    = PW_CHECK && !pw_ok;
    assign rsp_nxt.result = rsp_nxt.err ? 32'h0 : sum;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_buf
        p_addsub_arb_buf u_buf (
            .g_clk    (g_clk),
            .g_resetn (g_resetn),
            .load     (grant[i]),
            .drain    (rsp_ready[i]),
            .rsp_in   (rsp_nxt),
            .valid    (rsp_valid[i]),
            .rsp      (rsp[i])
        );
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)
            last <= 1'b1;
        else if (|grant)
            last <= grant[1];
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign rsp0_valid  = rsp_valid[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp0_result = rsp[0].result;
    assign rsp1_result = rsp[1].result;
    assign rsp0_err    = rsp[0].err;
    assign rsp1_err    = rsp[1].err;

endmodule
